// File: rtl/fill_pkg.sv
// Shared constants, FSM state type and coordinate helpers for the span filler.
package fill_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 8;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // Pull a column back onto the visible screen.
  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Linear frame-buffer address from (y, x): y*640 + x built from two shifts.
module fill_addr_gen
  import fill_pkg::*;
(
  input  logic [Y_W-1:0]    y,
  input  logic [X_W-1:0]    x,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] x_ext;

  assign y_ext = {{(ADDR_W - Y_W){1'b0}}, y};
  assign x_ext = {{(ADDR_W - X_W){1'b0}}, x};

  // 640 = 512 + 128, so the row offset is two shifted copies of y.
  assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;

endmodule

// File: rtl/fill_span_writer.sv
// Writes one horizontal span of a single colour into the frame buffer,
// one pixel per accepted write, then reports completion.
module fill_span_writer
  import fill_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_start,
  input  logic [X_W-1:0]     x_left,
  input  logic [X_W-1:0]     x_right,
  input  logic [Y_W-1:0]     y,
  input  logic [Y_W-1:0]     y_last,
  input  logic [COLOR_W-1:0] color,
  input  logic               wr_ack,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               fill_done,
  output logic               all_finish
);

  fill_state_t state, state_nxt;

  logic [X_W-1:0]     xa_r, xb_r;
  logic [X_W-1:0]     x_r, xe_r;
  logic [Y_W-1:0]     y_r, y_last_r;
  logic [COLOR_W-1:0] color_r;
  logic [X_W-1:0]     xs_c, xe_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               last_px;

  fill_addr_gen u_addr (
    .y    (y_r),
    .x    (x_r),
    .addr (addr_c)
  );

  // Order and clamp the captured endpoints for the SETUP cycle.
  always_comb begin
    xs_c = clamp_x((xa_r < xb_r) ? xa_r : xb_r);
    xe_c = clamp_x((xa_r < xb_r) ? xb_r : xa_r);
  end

  assign last_px = (x_r == xe_r);

  // Next-state selection; a request is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = SETUP;
      SETUP:   state_nxt = (y_r >= Y_LIM) ? DONE : WRITE;
      WRITE:   if (wr_ack && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM register and the sticky last-row flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      all_finish <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fill_start)
        all_finish <= 1'b0;
      else if (state != DONE && state_nxt == DONE)
        all_finish <= (y_r == y_last_r);
    end
  end

  // Span datapath: capture on accept, set up the walk, advance on each ack.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (fill_start) begin
          xa_r     <= x_left;
          xb_r     <= x_right;
          y_r      <= y;
          y_last_r <= y_last;
          color_r  <= color;
        end
      end
      SETUP: begin
        x_r  <= xs_c;
        xe_r <= xe_c;
      end
      WRITE: begin
        if (wr_ack && !last_px) x_r <= x_r + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are gated by state so reset forces them all low at once.
  always_comb begin
    wr_req    = (state == WRITE);
    wr_addr   = wr_req ? addr_c : '0;
    wr_data   = wr_req ? color_r : '0;
    fill_done = (state == DONE);
  end

endmodule
